// File: rtl/sound_sequencer.sv
// sound_sequencer
// Shares the piezo speaker between three game events (hit, start, end).
// Request pulses are latched into pending flags, the highest-priority one is
// granted (end > start > hit) and its note sequence is played as a square
// wave with a silent gap between notes. An end request aborts a running hit
// or start sequence.
//
// Ports:
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   hit_req    one-cycle pulse, mole hit (ignored while god_mode=1)
//   start_req  one-cycle pulse, game started
//   end_req    one-cycle pulse, game ended
//   god_mode   level, suppresses and flushes hit sounds
//   speaker    registered square-wave drive
//   busy       high while a sequence is playing (PLAY or GAP)
//   event_id   event playing: 0 none, 1 hit, 2 start, 3 end
module sound_sequencer #(
    parameter int unsigned HALF_LO  = 50000,
    parameter int unsigned HALF_MID = 37500,
    parameter int unsigned HALF_HI  = 25000,
    parameter int unsigned NOTE_LEN = 10000000,
    parameter int unsigned GAP_LEN  = 2000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       hit_req,
    input  logic       start_req,
    input  logic       end_req,
    input  logic       god_mode,
    output logic       speaker,
    output logic       busy,
    output logic [1:0] event_id
);

    typedef enum logic [1:0] {S_IDLE, S_PLAY, S_GAP} state_t;

    localparam logic [1:0] EV_NONE  = 2'd0;
    localparam logic [1:0] EV_HIT   = 2'd1;
    localparam logic [1:0] EV_START = 2'd2;
    localparam logic [1:0] EV_END   = 2'd3;

    state_t      r_state, w_state_nxt;
    logic [1:0]  r_event, w_event_nxt;
    logic [1:0]  r_idx, w_idx_nxt;
    logic [31:0] r_half_cnt, w_half_cnt_nxt;
    logic [31:0] r_note_cnt, w_note_cnt_nxt;
    logic [31:0] r_gap_cnt, w_gap_cnt_nxt;
    logic        r_spk, w_spk_nxt;
    logic        r_pend_hit, w_pend_hit_nxt;
    logic        r_pend_start, w_pend_start_nxt;
    logic        r_pend_end, w_pend_end_nxt;

    logic        w_hit_in, w_start_in, w_end_in;
    logic        w_grant;
    logic [1:0]  w_grant_ev;
    logic [31:0] w_half;
    logic        w_last;

    // Live request OR pending flag, so a request is granted in the same edge
    // it arrives. god_mode masks both the pulse and the stored hit flag.
    assign w_hit_in   = (hit_req | r_pend_hit) & ~god_mode;
    assign w_start_in = start_req | r_pend_start;
    assign w_end_in   = end_req | r_pend_end;

    // Half-period of the note currently selected by (event, note index).
    always_comb begin
        w_half = HALF_HI;
        case (r_event)
            EV_START: w_half = (r_idx == 2'd0) ? HALF_LO : HALF_HI;
            EV_END: begin
                case (r_idx)
                    2'd0:    w_half = HALF_HI;
                    2'd1:    w_half = HALF_MID;
                    default: w_half = HALF_LO;
                endcase
            end
            default: w_half = HALF_HI;
        endcase
    end

    // Sequence length equals the event code (hit 1, start 2, end 3 notes).
    assign w_last = (r_idx == r_event - 2'd1);

    always_comb begin
        w_state_nxt      = r_state;
        w_event_nxt      = r_event;
        w_idx_nxt        = r_idx;
        w_half_cnt_nxt   = r_half_cnt;
        w_note_cnt_nxt   = r_note_cnt;
        w_gap_cnt_nxt    = r_gap_cnt;
        w_spk_nxt        = r_spk;
        w_pend_hit_nxt   = w_hit_in;
        w_pend_start_nxt = w_start_in;
        w_pend_end_nxt   = w_end_in;
        w_grant          = 1'b0;
        w_grant_ev       = EV_NONE;

        case (r_state)
            S_IDLE: begin
                if (w_end_in) begin
                    w_grant    = 1'b1;
                    w_grant_ev = EV_END;
                end else if (w_start_in) begin
                    w_grant    = 1'b1;
                    w_grant_ev = EV_START;
                end else if (w_hit_in) begin
                    w_grant    = 1'b1;
                    w_grant_ev = EV_HIT;
                end
            end
            default: begin
                if (r_event != EV_END && w_end_in) begin
                    // Preempt: the running hit/start sequence is dropped.
                    w_grant    = 1'b1;
                    w_grant_ev = EV_END;
                end else if (r_state == S_PLAY) begin
                    if (r_note_cnt == NOTE_LEN - 32'd1) begin
                        w_spk_nxt = 1'b0;
                        if (w_last) begin
                            w_state_nxt = S_IDLE;
                            w_event_nxt = EV_NONE;
                        end else begin
                            w_state_nxt   = S_GAP;
                            w_gap_cnt_nxt = 32'd0;
                        end
                    end else begin
                        w_note_cnt_nxt = r_note_cnt + 32'd1;
                        if (r_half_cnt == w_half - 32'd1) begin
                            w_spk_nxt      = ~r_spk;
                            w_half_cnt_nxt = 32'd0;
                        end else begin
                            w_half_cnt_nxt = r_half_cnt + 32'd1;
                        end
                    end
                end else begin
                    if (r_gap_cnt == GAP_LEN - 32'd1) begin
                        w_state_nxt    = S_PLAY;
                        w_idx_nxt      = r_idx + 2'd1;
                        w_half_cnt_nxt = 32'd0;
                        w_note_cnt_nxt = 32'd0;
                    end else begin
                        w_gap_cnt_nxt = r_gap_cnt + 32'd1;
                    end
                end
            end
        endcase

        if (w_grant) begin
            w_state_nxt    = S_PLAY;
            w_event_nxt    = w_grant_ev;
            w_idx_nxt      = 2'd0;
            w_half_cnt_nxt = 32'd0;
            w_note_cnt_nxt = 32'd0;
            w_gap_cnt_nxt  = 32'd0;
            w_spk_nxt      = 1'b0;
            case (w_grant_ev)
                EV_END:   w_pend_end_nxt   = 1'b0;
                EV_START: w_pend_start_nxt = 1'b0;
                default:  w_pend_hit_nxt   = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_event      <= EV_NONE;
            r_idx        <= 2'd0;
            r_half_cnt   <= 32'd0;
            r_note_cnt   <= 32'd0;
            r_gap_cnt    <= 32'd0;
            r_spk        <= 1'b0;
            r_pend_hit   <= 1'b0;
            r_pend_start <= 1'b0;
            r_pend_end   <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_event      <= w_event_nxt;
            r_idx        <= w_idx_nxt;
            r_half_cnt   <= w_half_cnt_nxt;
            r_note_cnt   <= w_note_cnt_nxt;
            r_gap_cnt    <= w_gap_cnt_nxt;
            r_spk        <= w_spk_nxt;
            r_pend_hit   <= w_pend_hit_nxt;
            r_pend_start <= w_pend_start_nxt;
            r_pend_end   <= w_pend_end_nxt;
        end
    end

    assign speaker  = r_spk;
    assign busy     = (r_state != S_IDLE);
    assign event_id = r_event;

endmodule

// File: tb/tb_sound_sequencer.sv
// tb_sound_sequencer
// Directed scenarios plus randomized traffic for sound_sequencer. The
// reference model tracks only which event plays and how many edges have
// passed since its grant; the expected speaker level is derived from that
// elapsed time with plain arithmetic over the note/gap schedule.
module tb_sound_sequencer;

    localparam int HLO = 4;
    localparam int HMID = 3;
    localparam int HHI = 2;
    localparam int NL = 16;
    localparam int GL = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       hit_req = 1'b0;
    logic       start_req = 1'b0;
    logic       end_req = 1'b0;
    logic       god_mode = 1'b0;
    logic       speaker;
    logic       busy;
    logic [1:0] event_id;

    always #5 clk = ~clk;

    sound_sequencer #(
        .HALF_LO(HLO), .HALF_MID(HMID), .HALF_HI(HHI),
        .NOTE_LEN(NL), .GAP_LEN(GL)
    ) dut (
        .clk(clk), .rst_n(rst_n), .hit_req(hit_req), .start_req(start_req),
        .end_req(end_req), .god_mode(god_mode), .speaker(speaker),
        .busy(busy), .event_id(event_id)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    bit m_ph, m_ps, m_pe;
    int m_cur;   // 0 none, 1 hit, 2 start, 3 end
    int m_t;     // edges since grant

    function automatic int half_of(int ev, int idx);
        case (ev)
            1: return HHI;
            2: return (idx == 0) ? HLO : HHI;
            default: return (idx == 0) ? HHI : (idx == 1) ? HMID : HLO;
        endcase
    endfunction

    function automatic int total_of(int ev);
        return ev * NL + (ev - 1) * GL;
    endfunction

    function automatic int exp_spk();
        int i, o;
        if (m_cur == 0) return 0;
        i = m_t / (NL + GL);
        o = m_t % (NL + GL);
        if (o >= NL) return 0;
        return (o / half_of(m_cur, i)) % 2;
    endfunction

    task automatic model_reset();
        m_ph = 0; m_ps = 0; m_pe = 0; m_cur = 0; m_t = 0;
    endtask

    task automatic model_edge();
        bit hin, sin, ein;
        if (!rst_n) begin
            model_reset();
            return;
        end
        hin = (hit_req || m_ph) && !god_mode;
        sin = start_req || m_ps;
        ein = end_req || m_pe;
        m_ph = hin; m_ps = sin; m_pe = ein;
        if (m_cur == 0) begin
            if (ein)      begin m_cur = 3; m_t = 0; m_pe = 0; end
            else if (sin) begin m_cur = 2; m_t = 0; m_ps = 0; end
            else if (hin) begin m_cur = 1; m_t = 0; m_ph = 0; end
        end else if (m_cur != 3 && ein) begin
            m_cur = 3; m_t = 0; m_pe = 0;
        end else begin
            m_t++;
            if (m_t == total_of(m_cur)) begin
                m_cur = 0; m_t = 0;
            end
        end
    endtask

    // ---------------- stimulus helpers ----------------
    int bcnt;
    int evcnt[4];

    task automatic clr_counts();
        bcnt = 0;
        for (int i = 0; i < 4; i++) evcnt[i] = 0;
    endtask

    task automatic cyc(input bit h, input bit s, input bit e, input bit g);
        hit_req = h; start_req = s; end_req = e; god_mode = g;
        @(posedge clk);
        model_edge();
        #1;
        chk("speaker", {31'd0, speaker}, exp_spk());
        chk("busy", {31'd0, busy}, (m_cur != 0) ? 1 : 0);
        chk("event_id", {30'd0, event_id}, m_cur);
        if (busy === 1'b1) bcnt++;
        evcnt[event_id]++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, god_mode);
    endtask

    task automatic wait_idle(input int max);
        int n;
        n = 0;
        while (busy === 1'b1 && n < max) begin
            cyc(0, 0, 0, god_mode);
            n++;
        end
        if (busy !== 1'b0) chk("wait_idle_timeout", {31'd0, busy}, 0);
    endtask

    initial begin
        int n;
        model_reset();
        clr_counts();

        // Reset with random requests: outputs held at 0.
        rst_n = 1'b0;
        #1;
        chk("rst_spk", {31'd0, speaker}, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_ev", {30'd0, event_id}, 0);
        for (int i = 0; i < 3; i++)
            cyc(1'($urandom % 2), 1'($urandom % 2), 1'($urandom % 2), 1'b0);
        rst_n = 1'b1;
        clr_counts();
        idle(50);
        chk("post_rst_quiet", bcnt, 0);

        // Single hit: 16 busy cycles.
        clr_counts();
        cyc(1, 0, 0, 0);
        wait_idle(100);
        chk("hit_len", bcnt, 16);
        idle(3);

        // Start: 36 busy cycles.
        clr_counts();
        cyc(0, 1, 0, 0);
        wait_idle(100);
        chk("start_len", bcnt, 36);
        idle(3);

        // Hit and start together: start first, then hit.
        clr_counts();
        cyc(1, 1, 0, 0);
        chk("pri_first", {30'd0, event_id}, 2);
        idle(70);
        chk("pri_start_cnt", evcnt[2], 36);
        chk("pri_hit_cnt", evcnt[1], 16);

        // Preemption: end 10 cycles after start.
        clr_counts();
        cyc(0, 1, 0, 0);
        idle(9);
        cyc(0, 0, 1, 0);
        chk("preempt_ev", {30'd0, event_id}, 3);
        chk("preempt_spk", {31'd0, speaker}, 0);
        clr_counts();
        idle(80);
        chk("end_len", evcnt[3], 55);
        chk("start_dropped", evcnt[2], 0);

        // God mode masks a hit pulse.
        clr_counts();
        cyc(1, 0, 0, 1);
        idle(20);
        chk("god_hit_busy", bcnt, 0);
        cyc(0, 0, 0, 0);

        // Hit pending behind start is flushed when god_mode rises.
        clr_counts();
        cyc(1, 1, 0, 0);
        idle(5);
        cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 0);
        idle(80);
        chk("god_flush_hit", evcnt[1], 0);

        // Asynchronous reset mid-note silences the speaker immediately.
        cyc(1, 0, 0, 0);
        n = 0;
        while (speaker !== 1'b1 && n < 10) begin
            cyc(0, 0, 0, 0);
            n++;
        end
        chk("midnote_spk_high", {31'd0, speaker}, 1);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("async_rst_spk", {31'd0, speaker}, 0);
        chk("async_rst_busy", {31'd0, busy}, 0);
        cyc(0, 0, 0, 0);
        rst_n = 1'b1;
        idle(2);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            bit g;
            g = god_mode;
            if ($urandom % 100 == 0) g = ~g;
            cyc($urandom % 20 == 0, $urandom % 60 == 0, $urandom % 90 == 0, g);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
